bin_to_bcd_seq: RTL and testbench

Sequential double-dabble converter: turns an unsigned binary value into packed BCD digits for the display path, one shift per clock. It sits directly upstream of the per-digit BCD-to-7-segment decoders. Each 4-bit slice of its `bcd` output feeds one decoder's `bcd` input. A start/busy/done handshake lets a counter or control FSM request a conversion and latch the result.

---
 rtl/bin_to_bcd_seq.sv | 125 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-packed-BCD converter with start/busy/done handshake.
// Optional leading-zero blanking (digits forced to 4'hF) via macro BIN2BCD_LEADING_BLANK_EN.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state_q, state_d;
  logic [WORK_W-1:0]   work_q, work_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic                ovf_q, ovf_d;
  logic                done_q, done_d;

  logic [WORK_W-1:0]   adj;
  logic [WORK_W-1:0]   shifted;
  logic                carry_out;
  logic [BCD_W-1:0]    result;

`ifdef BIN2BCD_LEADING_BLANK_EN
  // Units digit is never blanked so that zero still shows "0".
  function automatic logic [BCD_W-1:0] blank_lead(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    logic             lead;
    r    = d;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (d[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
      else                               lead = 1'b0;
    end
    return r;
  endfunction
`endif

  always_comb begin
    adj = work_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[BIN_W + 4*i +: 4] >= 4'd5)
        adj[BIN_W + 4*i +: 4] = adj[BIN_W + 4*i +: 4] + 4'd3;
    end
    // A bit shifted out of the top digit means the value reached 10^DIGITS.
    carry_out = adj[WORK_W-1];
    shifted   = {adj[WORK_W-2:0], 1'b0};
`ifdef BIN2BCD_LEADING_BLANK_EN
    result    = blank_lead(shifted[WORK_W-1 -: BCD_W]);
`else
    result    = shifted[WORK_W-1 -: BCD_W];
`endif
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {{BCD_W{1'b0}}, bin};
          cnt_d   = '0;
          carry_d = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d  = shifted;
        carry_d = carry_q | carry_out;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = IDLE;
          done_d  = 1'b1;
          bcd_d   = result;
          ovf_d   = carry_q | carry_out;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 3-digit instance and a 2-digit instance for overflow.
module tb_bin_to_bcd_seq;

`ifdef BIN2BCD_LEADING_BLANK_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [7:0]  bin_a, bin_b;
  logic        busy_a, done_a, ovf_a;
  logic        busy_b, done_b, ovf_b;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a)
  );

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a conversion on dut_a and checks the full 8-cycle timeline; ends in the done cycle.
  task automatic conv_a(input logic [7:0] v, input logic [11:0] exp_bcd, input string tag);
    bin_a   = v;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check({tag, " busy_at_k"}, 32'(busy_a), 32'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      check({tag, " no_early_done"}, {30'd0, busy_a, done_a}, 32'b10);
    end
    tick();
    check({tag, " done_busy"}, {30'd0, busy_a, done_a}, 32'b01);
    check({tag, " bcd"}, 32'(bcd_a), 32'(exp_bcd));
    check({tag, " ovf"}, 32'(ovf_a), 32'd0);
  endtask

  task automatic conv_b(input logic [7:0] v, input logic [7:0] exp_bcd, input logic exp_ovf,
                        input string tag);
    bin_b   = v;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (7) tick();
    check({tag, " pre_done"}, 32'(done_b), 32'd0);
    tick();
    check({tag, " done"}, 32'(done_b), 32'd1);
    check({tag, " bcd"}, 32'(bcd_b), 32'(exp_bcd));
    check({tag, " ovf"}, 32'(ovf_b), 32'(exp_ovf));
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; bin_a = 8'd0; bin_b = 8'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset done", 32'(done_a), 32'd0);
    check("reset bcd", 32'(bcd_a), 32'd0);
    check("reset ovf", 32'(ovf_a), 32'd0);
    check("reset b", {22'd0, busy_b, done_b, bcd_b}, 32'd0);

    conv_a(8'd0, BL ? 12'hFF0 : 12'h000, "zero");
    tick();

    // Back-to-back: each start is raised during the previous done cycle.
    conv_a(8'd255, 12'h255, "b2b_255");
    conv_a(8'd99,  BL ? 12'hF99 : 12'h099, "b2b_99");
    conv_a(8'd100, 12'h100, "b2b_100");
    tick();
    check("after_b2b idle", {30'd0, busy_a, done_a}, 32'd0);
    check("after_b2b hold", 32'(bcd_a), 32'h100);

    // Start ignored while busy and bin changes after acceptance.
    bin_a = 8'd42; start_a = 1'b1;
    tick();
    start_a = 1'b0; bin_a = 8'd200;
    tick(); tick();
    bin_a = 8'd7; start_a = 1'b1;
    tick();
    start_a = 1'b0; bin_a = 8'd13;
    repeat (4) tick();
    check("ignore pre_done", 32'(done_a), 32'd0);
    tick();
    check("ignore done", 32'(done_a), 32'd1);
    check("ignore bcd", 32'(bcd_a), BL ? 32'hF42 : 32'h042);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ignore single_done", {30'd0, busy_a, done_a}, 32'd0);
    end

    // Reset at k+4 of a conversion aborts it.
    bin_a = 8'd123; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 32'(busy_a), 32'd0);
    check("abort done", 32'(done_a), 32'd0);
    check("abort bcd", 32'(bcd_a), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort no_done", 32'(done_a), 32'd0);
    end
    conv_a(8'd123, 12'h123, "after_abort");
    tick();

    conv_a(8'd7,   BL ? 12'hFF7 : 12'h007, "seven");
    tick();
    conv_a(8'd205, 12'h205, "interior_zero");
    tick();

    // Two-digit instance: overflow truncates to the low digits.
    conv_b(8'd100, BL ? 8'hF0 : 8'h00, 1'b1, "d2_100");
    repeat (3) tick();
    check("d2 ovf_held", 32'(ovf_b), 32'd1);
    conv_b(8'd99,  8'h99, 1'b0, "d2_99");
    tick();
    conv_b(8'd255, 8'h55, 1'b1, "d2_255");
    tick();
    conv_b(8'd5,   BL ? 8'hF5 : 8'h05, 1'b0, "d2_5");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
